// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Logic, compare, add and subtract complete in one
// cycle. MOD and DIV with a nonzero divisor run a restoring divider that
// handles one quotient bit per cycle, for WIDTH cycles.
//
// Ports:
//   Clk      - clock; all state changes on the rising edge
//   Reset    - asynchronous reset, active low
//   Start    - operation request; accepted only while not Busy
//   A, B     - operands, sampled with Start
//   ALUOp    - opcode, sampled with Start
//   Result   - registered result, held until the next completion
//   C        - carry-out (ADD) / no-borrow (SUB), else 0
//   V        - signed overflow (ADD/SUB), else 0
//   DivZero  - divide by zero on MOD/DIV, else 0
//   Busy     - divider iteration in progress
//   We       - one-cycle pulse marking a new Result/C/V/DivZero
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] Result,
    output logic             C,
    output logic             V,
    output logic             DivZero,
    output logic             Busy,
    output logic             We
);

    localparam logic IDLE = 1'b0;
    localparam logic ITER = 1'b1;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_LESS  = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;
    localparam logic [3:0] OP_DIV   = 4'd8;
    localparam logic [3:0] OP_LESSU = 4'd9;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             mod_q, mod_d;
    logic [WIDTH-1:0] result_d;
    logic             c_d, v_d, dz_d, we_d;

    // Single-cycle datapath
    logic [WIDTH:0]   sum, diff;
    logic             lt_s, lt_u;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_dz;
    logic             start_iter;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign lt_s = $signed(A) < $signed(B);
    assign lt_u = A < B;
    assign start_iter = ((ALUOp == OP_MOD) || (ALUOp == OP_DIV)) && (B != '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        case (ALUOp)
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_NOR:   alu_res = ~(A | B);
            OP_LESS:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_LESSU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            // Divide ops reach this path only with a zero divisor
            OP_MOD: begin
                alu_res = A;
                alu_dz  = 1'b1;
            end
            OP_DIV: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // One restoring-division step. The shifted remainder needs one extra bit;
    // when it is >= divisor the true difference fits in WIDTH bits.
    logic [WIDTH:0]   rem_sh;
    logic             take;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign take   = rem_sh >= {1'b0, dvs_q};
    assign rem_nx = take ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], take};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        mod_d    = mod_q;
        result_d = Result;
        c_d      = C;
        v_d      = V;
        dz_d     = DivZero;
        we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (start_iter) begin
                        rem_d   = '0;
                        quo_d   = A;
                        dvs_d   = B;
                        mod_d   = (ALUOp == OP_MOD);
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ITER;
                    end else begin
                        result_d = alu_res;
                        c_d      = alu_c;
                        v_d      = alu_v;
                        dz_d     = alu_dz;
                        we_d     = 1'b1;
                    end
                end
            end
            default: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = mod_q ? rem_nx : quo_nx;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    dz_d     = 1'b0;
                    we_d     = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            mod_q   <= 1'b0;
            Result  <= '0;
            C       <= 1'b0;
            V       <= 1'b0;
            DivZero <= 1'b0;
            We      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            mod_q   <= mod_d;
            Result  <= result_d;
            C       <= c_d;
            V       <= v_d;
            DivZero <= dz_d;
            We      <= we_d;
        end
    end

    assign Busy = (state_q == ITER);

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=32): directed cases with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_alu_mc;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    ALUOp = '0;
    logic [W-1:0]  Result;
    logic          C, V, DivZero, Busy, We;

    always #5 Clk = ~Clk;

    alu_mc #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .ALUOp(ALUOp),
        .Result(Result), .C(C), .V(V), .DivZero(DivZero), .Busy(Busy), .We(We)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        dz;
    } exp_t;

    // Reference results from plain arithmetic
    function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        exp_t r;
        longint sa, sb, ss;
        longint unsigned ua, ub, us;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd0: r.res = a & b;
            4'd1: r.res = a | b;
            4'd2: r.res = a ^ b;
            4'd3: r.res = ~(a | b);
            4'd4: r.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: begin
                us = ua + ub;
                r.res = us[31:0];
                r.c = (us > 64'hFFFF_FFFF);
                ss = sa + sb;
                r.v = (ss > MAXS) || (ss < MINS);
            end
            4'd6: begin
                r.res = a - b;
                r.c = (ua >= ub);
                ss = sa - sb;
                r.v = (ss > MAXS) || (ss < MINS);
            end
            4'd7: begin
                if (b == 32'd0) begin r.res = a; r.dz = 1'b1; end
                else r.res = a % b;
            end
            4'd8: begin
                if (b == 32'd0) begin r.res = '1; r.dz = 1'b1; end
                else r.res = a / b;
            end
            4'd9: r.res = (ua < ub) ? 32'd1 : 32'd0;
            default: ;
        endcase
        return r;
    endfunction

    // Model: an iterative op keeps the unit busy for W cycles after acceptance,
    // then its precomputed result appears with a We pulse.
    exp_t   now_e;
    exp_t   m_pend = '0;
    int     m_left = 0;
    logic          exp_we = 1'b0, exp_busy = 1'b0;
    logic [W-1:0]  exp_res = '0;
    logic          exp_c = 1'b0, exp_v = 1'b0, exp_dz = 1'b0;

    assign now_e = ref_op(ALUOp, A, B);

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_left <= 0; exp_we <= 1'b0; exp_busy <= 1'b0;
            exp_res <= '0; exp_c <= 1'b0; exp_v <= 1'b0; exp_dz <= 1'b0;
        end else if (m_left > 0) begin
            m_left   <= m_left - 1;
            exp_busy <= (m_left > 1);
            if (m_left == 1) begin
                exp_we <= 1'b1; exp_res <= m_pend.res;
                exp_c <= m_pend.c; exp_v <= m_pend.v; exp_dz <= m_pend.dz;
            end else begin
                exp_we <= 1'b0;
            end
        end else if (Start) begin
            if ((ALUOp == 4'd7 || ALUOp == 4'd8) && B != '0) begin
                m_left <= W; m_pend <= now_e; exp_busy <= 1'b1; exp_we <= 1'b0;
            end else begin
                exp_we <= 1'b1; exp_busy <= 1'b0; exp_res <= now_e.res;
                exp_c <= now_e.c; exp_v <= now_e.v; exp_dz <= now_e.dz;
            end
        end else begin
            exp_we <= 1'b0;
        end
    end

    always @(negedge Clk) begin
        chk("we", 64'(We), 64'(exp_we));
        chk("busy", 64'(Busy), 64'(exp_busy));
        chk("result", 64'(Result), 64'(exp_res));
        if (exp_we) begin
            chk("c", 64'(C), 64'(exp_c));
            chk("v", 64'(V), 64'(exp_v));
            chk("divzero", 64'(DivZero), 64'(exp_dz));
        end
    end

    // Issue one op at a negedge, return at the negedge where We is seen.
    // lat counts negedges from issue; an iterative op shows We at W+1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        ALUOp = op; A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!We && lat < 100) begin
            if (Busy) busy_cyc++;
            @(negedge Clk);
            lat++;
        end
        chk("we_timeout", 64'(We), 64'd1);
    endtask

    logic [3:0]  t_op [6] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd9};
    logic [31:0] t_a  [6] = '{32'd1, 32'd500, -32'sd100, -32'sd500, -32'sd1, -32'sd1};
    logic [31:0] t_b  [6] = '{32'd100, 32'd333, -32'sd300, -32'sd300, 32'd100, 32'd100};
    logic [31:0] t_r  [6] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0};

    initial begin
        int lat, bc, k;
        exp_t e;

        // Pin the model with hand-computed values
        e = ref_op(4'd5, 32'hFFFF_FFFF, 32'd1);
        chk("model_add_res", 64'(e.res), 64'd0);
        chk("model_add_c", 64'(e.c), 64'd1);
        e = ref_op(4'd5, 32'h7FFF_FFFF, 32'd1);
        chk("model_add_v", 64'(e.v), 64'd1);
        e = ref_op(4'd6, 32'd5, 32'd3);
        chk("model_sub", 64'({e.res, e.c}), 64'({32'd2, 1'b1}));
        e = ref_op(4'd7, 32'd42, 32'd11);
        chk("model_mod", 64'(e.res), 64'd9);

        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_flags", 64'({We, Busy, C, V, DivZero}), 64'd0);
        Reset = 1'b1;
        @(negedge Clk);

        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, lat, bc);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_wrap", 64'({Result, C, V}), 64'({32'd0, 1'b1, 1'b0}));
        run_op(4'd5, 32'h7FFF_FFFF, 32'd1, lat, bc);
        chk("add_ovf", 64'({Result, V}), 64'({32'h8000_0000, 1'b1}));

        // Back-to-back single-cycle compares
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, bc);
            chk("less_lat", 64'(lat), 64'd1);
            chk("less_res", 64'(Result), 64'(t_r[i]));
        end

        run_op(4'd7, 32'd42, 32'd11, lat, bc);
        chk("mod_lat", 64'(lat), 64'(W + 1));
        chk("mod_busy", 64'(bc), 64'(W));
        chk("mod_res", 64'(Result), 64'd9);
        @(negedge Clk);
        chk("mod_single_we", 64'(We), 64'd0);
        run_op(4'd8, 32'd16, 32'd5, lat, bc);
        chk("div_lat", 64'(lat), 64'(W + 1));
        chk("div_res", 64'(Result), 64'd3);

        run_op(4'd7, 32'd7, 32'd0, lat, bc);
        chk("mod0", 64'({Result, DivZero, C, V}), 64'({32'd7, 3'b100}));
        chk("mod0_lat", 64'(lat), 64'd1);
        run_op(4'd8, 32'd7, 32'd0, lat, bc);
        chk("div0", 64'({Result, DivZero}), 64'({32'hFFFF_FFFF, 1'b1}));
        run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        chk("reserved", 64'({Result, C, V, DivZero}), 64'd0);
        chk("reserved_lat", 64'(lat), 64'd1);

        // DIV with a Start and operand churn while busy
        ALUOp = 4'd8; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        k = 1;
        while (!We && k < 100) begin
            A = $urandom; B = $urandom;
            if (k == 5) begin Start = 1'b1; ALUOp = 4'd5; A = 32'd1; B = 32'd1; end
            else Start = 1'b0;
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        chk("div_ign_lat", 64'(k), 64'(W + 1));
        chk("div_ign_res", 64'(Result), 64'd14);
        run_op(4'd5, 32'd1, 32'd1, lat, bc);
        chk("add_after", 64'(Result), 64'd2);

        // Reset in the middle of a MOD
        ALUOp = 4'd7; A = 32'd1000; B = 32'd13; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("abort_result", 64'(Result), 64'd0);
        chk("abort_flags", 64'({We, Busy, C, V, DivZero}), 64'd0);
        Start = 1'b1; ALUOp = 4'd5; A = 32'd3; B = 32'd4;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("after_rel", 64'({Result, We, Busy}), 64'd0);
        run_op(4'd6, 32'd5, 32'd3, lat, bc);
        chk("sub_after_rst", 64'({Result, C}), 64'({32'd2, 1'b1}));

        // Randomized run against the model
        for (int i = 0; i < 2500; i++) begin
            Start = ($urandom_range(0, 2) != 0);
            ALUOp = 4'($urandom_range(0, 15));
            A = $urandom;
            if ($urandom_range(0, 3) == 0) A = $urandom_range(0, 1000);
            case ($urandom_range(0, 7))
                0: B = '0;
                1: B = $urandom_range(1, 20);
                2: B = A;
                default: B = $urandom;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                #2 Reset = 1'b0;
                @(negedge Clk);
                Reset = 1'b1;
            end else begin
                @(negedge Clk);
            end
        end
        Start = 1'b0;
        repeat (40) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
